chunked_addsub: RTL and testbench
=================================

// Module: chunked_addsub
// PURPOSE
//   Parametrised, multi-cycle add/subtract unit computing A + (SUB ? ~B : B) + cin.
//   Processes CHUNK bits per cycle with a registered ripple carry, so wide operands
//   close timing.
//   Valid/ready handshakes on both sides; supersedes the fixed 4-bit combinational
//   subtractor in the arithmetic datapath.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; WIDTH % CHUNK must be 0
//   CHUNK   4  bits computed per cycle; NCHUNK = WIDTH/CHUNK (1 => single-cycle compute)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      unit can accept operands
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_sub     in   1      0 = add B, 1 = add ~B (subtract when in_cin = 1)
//   in_cin     in   1      carry into bit 0
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_result out  WIDTH  sum/difference
//   out_cout   out  1      carry out of MSB (subtract: 1 = no borrow)
//   out_ovf    out  1      signed (two's-complement) overflow
//   out_zero   out  1      out_result == 0
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out_result, out_cout,
//   out_ovf, out_zero = 0; chunk index = 0. Reset mid-operation discards the operation.
// - FSM IDLE -> CALC -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid && in_ready, latch A, B' = in_sub ? ~in_b : in_b,
//     and carry = in_cin; index <= 0; go to CALC.
//   - CALC: in_ready=0. Each cycle, chunk[index] = A[chunk] + B'[chunk] + carry;
//     write it into the result register and update carry. After chunk NCHUNK-1,
//     go to DONE.
//   - DONE: out_valid=1 and all outputs stable. Hold until out_ready=1; on that edge
//     out_valid <= 0 and go to IDLE.
// - Latency: out_valid rises exactly NCHUNK cycles after the accept edge. Throughput is
//   one operation per NCHUNK+2 cycles.
// - in_ready=0 in CALC and DONE. No accept and release in the same cycle; in_valid
//   outside IDLE is ignored.
// - Flags, registered with the final chunk:
//   - out_cout = carry out of bit WIDTH-1.
//   - out_ovf = carry into MSB XOR carry out of MSB.
//   - out_zero is evaluated on the final out_result (after saturation, if enabled).
// - Wrap-around: result is mod 2^WIDTH. No sticky state between operations.
// CONFIGURATION
// - ADDSUB_SAT_EN defined: when out_ovf=1, out_result saturates to 0x7F..F (A MSB = 0)
//   or 0x80..0 (A MSB = 1). out_ovf and out_cout still report the raw overflow/carry.
// - ADDSUB_SAT_EN undefined: out_result is the wrapped sum. Saturation logic is absent.
// TESTING (defaults WIDTH=16, CHUNK=4 unless noted)
// 1. sub=1, cin=1, A=0x0005, B=0x0006 -> result 0xFFFF, cout 0, ovf 0, zero 0;
//    out_valid exactly 4 cycles after accept.
// 2. sub=1, cin=1, A=0x0009, B=0x0007 -> 0x0002, cout 1, ovf 0. Then sub=0, cin=0,
//    A=0xFFFF, B=0x0001 -> 0x0000, cout 1, zero 1.
// 3. sub=0, cin=0, A=0x7FFF, B=0x0001 -> ovf 1, cout 0; result 0x8000 without
//    ADDSUB_SAT_EN, 0x7FFF with it.
// 4. Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0, in_valid
//    pulses ignored; then out_ready=1 -> IDLE next cycle.
// 5. Assert rst_n=0 during CALC (index 2) -> all outputs go to reset values
//    immediately; the next operation is correct.
// 6. CHUNK=16 build: 0x1234 + 0x1111 -> 0x2345, latency 1 cycle.

Source files
------------

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: A + (sub ? ~B : B) + cin, CHUNK bits per cycle with a registered carry.
// Optional output saturation on signed overflow is built in when ADDSUB_SAT_EN is defined.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [1:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready is high only in IDLE; out_valid is high only in DONE.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK:0]   csum;
    logic             msb_cin;
    logic             raw_ovf;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] final_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        // Operands shift right each cycle, so the active chunk is always in the low bits
        // and the result fills in from the top.
        csum    = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        msb_cin = csum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
        raw_ovf = msb_cin ^ csum[CHUNK];
        shifted = result_q >> CHUNK;
        shifted[WIDTH-1 -: CHUNK] = csum[CHUNK-1:0];
        final_res = shifted;
`ifdef ADDSUB_SAT_EN
        // On the final chunk a_q[CHUNK-1] is the original sign bit of A.
        if (raw_ovf) begin
            final_res = {a_q[CHUNK-1], {(WIDTH-1){~a_q[CHUNK-1]}}};
        end
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_sub ? ~in_b : in_b;
                    carry_d  = in_cin;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                a_d      = a_q >> CHUNK;
                b_d      = b_q >> CHUNK;
                carry_d  = csum[CHUNK];
                idx_d    = idx_q + IDX_W'(1);
                result_d = shifted;
                if (idx_q == LAST_IDX) begin
                    idx_d    = '0;
                    result_d = final_res;
                    cout_d   = csum[CHUNK];
                    ovf_d    = raw_ovf;
                    zero_d   = (final_res == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_cout   = cout_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// Self-checking bench for chunked_addsub: directed vectors, random operations against an
// arithmetic reference model, DONE hold, mid-operation reset and back-to-back streaming.
module tb_chunked_addsub;
  parameter int WIDTH = 16;
  parameter int CHUNK = 4;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int EW = WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the full-width operands.
  function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic sub, input logic cin);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] res;
    logic             ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(cin);
    res  = full[WIDTH-1:0];
    ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    if (ovf) res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return {res, full[WIDTH], ovf, (res == '0)};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {out_result, out_cout, out_ovf, out_zero};
  endfunction

  // driver: present one operation, wait for accept, then for out_valid (out_ready held low)
  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic cin, output int lat);
    int guard;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // one full checked operation
  task automatic check_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic cin);
    int lat;
    logic [EW-1:0] exp;
    exp = model(a, b, sub, cin);
    drive_op(a, b, sub, cin, lat);
    n_tests++;
    if (lat !== NCHUNK || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d (valid=%b), expected %0d", name, lat, out_valid, NCHUNK);
    end
    n_tests++;
    if (observed() !== exp) begin
      n_fail++;
      $display("FAIL %s result: got res=%h cout=%b ovf=%b zero=%b, expected res=%h cout=%b ovf=%b zero=%b",
               name, out_result, out_cout, out_ovf, out_zero,
               exp[EW-1:3], exp[2], exp[1], exp[0]);
    end
    release_result();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got valid=%b ready=%b, expected valid=0 ready=1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 ||
        out_cout !== 1'b0 || out_ovf !== 1'b0 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got ready=%b valid=%b res=%h cout=%b ovf=%b zero=%b, expected 1 0 0 0 0 0",
               name, in_ready, out_valid, out_result, out_cout, out_ovf, out_zero);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    check_op("sub_5_6",     WIDTH'(16'h0005), WIDTH'(16'h0006), 1'b1, 1'b1);
    check_op("sub_9_7",     WIDTH'(16'h0009), WIDTH'(16'h0007), 1'b1, 1'b1);
    check_op("add_wrap",    {WIDTH{1'b1}},    WIDTH'(1),        1'b0, 1'b0);
    check_op("add_ovf_pos", {1'b0, {(WIDTH-1){1'b1}}}, WIDTH'(1), 1'b0, 1'b0);
    check_op("sub_ovf_neg", {1'b1, {(WIDTH-1){1'b0}}}, WIDTH'(1), 1'b1, 1'b1);
    check_op("add_1234",    WIDTH'(16'h1234), WIDTH'(16'h1111), 1'b0, 1'b0);
    check_op("cin_chain",   {WIDTH{1'b1}},    '0,               1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      check_op($sformatf("rand%0d", i), WIDTH'($urandom), WIDTH'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [EW-1:0] exp;
    exp = model(WIDTH'(16'h4321), WIDTH'(16'h0123), 1'b1, 1'b1);
    drive_op(WIDTH'(16'h4321), WIDTH'(16'h0123), 1'b1, 1'b1, lat);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== exp) begin
        n_fail++;
        $display("FAIL hold%0d: got valid=%b ready=%b obs=%h, expected valid=1 ready=0 obs=%h",
                 c, out_valid, in_ready, observed(), exp);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
    // the in_valid pulses during DONE must not have started anything
    repeat (2) @(posedge clk);
    #1 n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ignored: got valid=%b ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_a = WIDTH'(16'h5A5A); in_b = WIDTH'(16'h0F0F); in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset", WIDTH'(16'h0F00), WIDTH'(16'h00F0), 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int accepted;
    int checked;
    int last_acc;
    int cyc;
    logic acc;
    logic xfer;
    logic [EW-1:0] obs;
    logic [EW-1:0] exp;
    accepted = 0; checked = 0; last_acc = -1; cyc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    in_sub = 1'($urandom_range(0, 1)); in_cin = 1'($urandom_range(0, 1));
    while ((accepted < 6 || exp_q.size() != 0) && cyc < 200) begin
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      obs  = observed();
      if (acc) exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
      @(posedge clk);
      #1 cyc++;
      if (acc) begin
        if (last_acc >= 0) begin
          n_tests++;
          if (cyc - last_acc !== NCHUNK + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", cyc - last_acc, NCHUNK + 2);
          end
        end
        last_acc = cyc;
        accepted++;
        in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
        in_sub = 1'($urandom_range(0, 1)); in_cin = 1'($urandom_range(0, 1));
        if (accepted >= 6) in_valid = 1'b0;
      end
      if (xfer) begin
        exp = exp_q.pop_front();
        checked++;
        n_tests++;
        if (obs !== exp) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h, expected %h", checked, obs, exp);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (checked !== 6) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, expected 6", checked);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
